// File: rtl/lc3_uop_pkg.sv
// Shared definitions for the LC-3 microsequencer: microword field positions,
// COND encodings, FSM states and the default fetch microstate.
package lc3_uop_pkg;

  localparam int J_LSB    = 0;
  localparam int J_MSB    = 5;
  localparam int COND_LSB = 6;
  localparam int COND_MSB = 8;
  localparam int IRD_BIT  = 9;
  localparam int CTRL_LSB = 10;

  // FETCH is the first microstate executed after reset
  localparam logic [5:0] DEFAULT_RESET_STATE = 6'd18;

  typedef enum logic [2:0] {
    COND_NONE      = 3'b000,
    COND_MEM_R     = 3'b001,
    COND_BEN       = 3'b010,
    COND_ADDR_MODE = 3'b011,
    COND_PSR15     = 3'b100,
    COND_INT       = 3'b101,
    COND_RSVD6     = 3'b110,
    COND_RSVD7     = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/lc3_microsequencer_next_addr.sv
// Combinational next-microaddress logic: IRD opcode dispatch, otherwise the
// J field with one status bit ORed in as selected by COND.
module lc3_next_addr
  import lc3_uop_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [5:0]        j,
  input  logic [2:0]        cond,
  input  logic              ird,
  input  logic [3:0]        opcode,
  input  logic              addr_mode,
  input  logic              ben,
  input  logic              mem_r,
  input  logic              psr15,
  input  logic              int_pending,
  output logic [ADDR_W-1:0] next_addr
);

  logic [5:0] or_mask;
  logic [5:0] j_or;

  // Select the single status bit to merge into J; reserved codes merge nothing
  always_comb begin
    or_mask = 6'b000000;
    case (cond)
      COND_MEM_R:     or_mask[1] = mem_r;
      COND_BEN:       or_mask[2] = ben;
      COND_ADDR_MODE: or_mask[0] = addr_mode;
      COND_PSR15:     or_mask[3] = psr15;
      COND_INT:       or_mask[4] = int_pending;
      default:        or_mask = 6'b000000;
    endcase
    // Pure bitwise OR: no carry, so the result always stays within 0..63
    j_or = j | or_mask;
    next_addr = ird ? ADDR_W'({2'b00, opcode}) : ADDR_W'(j_or);
  end

endmodule

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: drives the control store read port, tracks the
// address of the live microword and qualifies its control field.
module lc3_microsequencer
  import lc3_uop_pkg::*;
#(
  parameter int                ADDR_W      = 6,
  parameter int                WORD_W      = 52,
  parameter logic [ADDR_W-1:0] RESET_STATE = ADDR_W'(DEFAULT_RESET_STATE)
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_n,
  input  logic                 i_stall,
  input  logic [15:0]          i_ir,
  input  logic                 i_ben,
  input  logic                 i_mem_r,
  input  logic                 i_psr15,
  input  logic                 i_int,
  output logic                 o_cs_en,
  output logic [ADDR_W-1:0]    o_cs_addr,
  input  logic [WORD_W-1:0]    i_cs_data,
  output logic [WORD_W-11:0]   o_ctrl,
  output logic                 o_uop_valid,
  output logic [ADDR_W-1:0]    o_upc
);

  state_e            state_reg;
  state_e            state_next;
  logic [ADDR_W-1:0] upc_reg;
  logic [ADDR_W-1:0] next_addr;
  logic              cs_en;
  logic [ADDR_W-1:0] cs_addr;
  logic              uop_valid;

  // Only the opcode and addressing-mode bit of IR steer sequencing
  logic unused_ir;
  assign unused_ir = ^i_ir[10:0];

  lc3_next_addr #(
    .ADDR_W(ADDR_W)
  ) u_next_addr (
    .j           (i_cs_data[J_MSB:J_LSB]),
    .cond        (i_cs_data[COND_MSB:COND_LSB]),
    .ird         (i_cs_data[IRD_BIT]),
    .opcode      (i_ir[15:12]),
    .addr_mode   (i_ir[11]),
    .ben         (i_ben),
    .mem_r       (i_mem_r),
    .psr15       (i_psr15),
    .int_pending (i_int),
    .next_addr   (next_addr)
  );

  // Next-state and read-port control; stall gates enable and valid with no delay
  always_comb begin
    state_next = state_reg;
    cs_en      = 1'b0;
    cs_addr    = RESET_STATE;
    uop_valid  = 1'b0;
    case (state_reg)
      ST_RESET: begin
        state_next = ST_PRIME;
      end
      ST_PRIME: begin
        cs_en      = 1'b1;
        cs_addr    = RESET_STATE;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        cs_en     = !i_stall;
        uop_valid = !i_stall;
        cs_addr   = next_addr;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // State register and microPC; the microPC follows every issued read
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state_reg <= ST_RESET;
      upc_reg   <= RESET_STATE;
    end else begin
      state_reg <= state_next;
      if (cs_en) begin
        upc_reg <= cs_addr;
      end
    end
  end

  assign o_cs_en     = cs_en;
  assign o_cs_addr   = cs_addr;
  assign o_uop_valid = uop_valid;
  assign o_upc       = upc_reg;
  assign o_ctrl      = i_cs_data[WORD_W-1:CTRL_LSB];

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Directed testbench: microsequencer paired with a behavioural control store
// loaded with a small test microcode image.
module tb_lc3_microsequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [15:0] ir;
  logic        ben;
  logic        mem_r;
  logic        psr15;
  logic        intr;
  logic        cs_en;
  logic [5:0]  cs_addr;
  logic [51:0] cs_data;
  logic [41:0] ctrl;
  logic        uop_valid;
  logic [5:0]  upc;

  logic [51:0] rom [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc3_microsequencer dut (
    .i_CLK       (clk),
    .i_RST_n     (rst_n),
    .i_stall     (stall),
    .i_ir        (ir),
    .i_ben       (ben),
    .i_mem_r     (mem_r),
    .i_psr15     (psr15),
    .i_int       (intr),
    .o_cs_en     (cs_en),
    .o_cs_addr   (cs_addr),
    .i_cs_data   (cs_data),
    .o_ctrl      (ctrl),
    .o_uop_valid (uop_valid),
    .o_upc       (upc)
  );

  // Synchronous-read control store
  always @(posedge clk) begin
    if (cs_en) cs_data <= rom[cs_addr];
  end

  // One line per cycle
  always @(negedge clk) begin
    $display("t=%0t rst_n=%b stall=%b upc=%0d valid=%b cs_en=%b cs_addr=%0d",
             $time, rst_n, stall, upc, uop_valid, cs_en, cs_addr);
  end

  function automatic logic [41:0] tag(input int a);
    return 42'(64'hA5A00 + a);
  endfunction

  function automatic logic [51:0] mk(input int a, input logic ird,
                                     input logic [2:0] cond, input logic [5:0] j);
    return {tag(a), ird, cond, j};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (uop_valid !== 1'b0) begin
        $display("FAIL reset_valid got %b want 0", uop_valid); n_fail++;
      end
      n_checks++;
      if (cs_en !== 1'b0 || upc !== 6'd18 || cs_addr !== 6'd18) begin
        $display("FAIL reset_state got cs_en=%b upc=%0d cs_addr=%0d want 0/18/18",
                 cs_en, upc, cs_addr); n_fail++;
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (uop_valid !== 1'b0 || cs_en !== 1'b1 || cs_addr !== 6'd18) begin
      $display("FAIL prime got valid=%b cs_en=%b cs_addr=%0d want 0/1/18",
               uop_valid, cs_en, cs_addr); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (uop_valid !== 1'b1 || upc !== 6'd18 || cs_en !== 1'b1) begin
      $display("FAIL first_uop got valid=%b upc=%0d cs_en=%b want 1/18/1",
               uop_valid, upc, cs_en); n_fail++;
    end
    n_checks++;
    if (ctrl !== tag(18) || cs_addr !== 6'd32) begin
      $display("FAIL first_word got ctrl=%h cs_addr=%0d want %h/32",
               ctrl, cs_addr, tag(18)); n_fail++;
    end
  endtask

  // Entry: upc=18. Exit: upc=15.
  task automatic test_ird();
    ir = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd32 || cs_addr !== 6'd1) begin
      $display("FAIL ird_1234 got upc=%0d cs_addr=%0d want 32/1", upc, cs_addr); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd1) begin
      $display("FAIL ird_target1 got %0d want 1", upc); n_fail++;
    end
    ir = 16'hF025;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd32 || cs_addr !== 6'd15) begin
      $display("FAIL ird_F025 got upc=%0d cs_addr=%0d want 32/15", upc, cs_addr); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd15 || ctrl !== tag(15)) begin
      $display("FAIL ird_target15 got upc=%0d ctrl=%h want 15/%h", upc, ctrl, tag(15)); n_fail++;
    end
  endtask

  // Entry: upc=15. Exit: upc=35.
  task automatic test_mem_wait();
    mem_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (upc !== 6'd33 || uop_valid !== 1'b1) begin
        $display("FAIL mem_wait[%0d] got upc=%0d valid=%b want 33/1", i, upc, uop_valid);
        n_fail++;
      end
    end
    mem_r = 1'b1;
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd35) begin
      $display("FAIL mem_ready got %0d want 35", upc); n_fail++;
    end
    mem_r = 1'b0;
  endtask

  // Entry: upc=35. Exit: upc=18.
  task automatic test_branch();
    ben = 1'b1;
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd22) begin
      $display("FAIL ben_taken got %0d want 22", upc); n_fail++;
    end
    ben = 1'b0;
    ir  = 16'h0800;
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd21) begin
      $display("FAIL addr_mode got %0d want 21", upc); n_fail++;
    end
    ir = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd35) begin
      $display("FAIL int_clear got %0d want 35", upc); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd18) begin
      $display("FAIL ben_not_taken got %0d want 18", upc); n_fail++;
    end
  endtask

  // Every status input high: each COND picks only its own bit. Entry/exit upc=18.
  task automatic test_all_status_high();
    logic [5:0] seq [10] = '{6'd32, 6'd15, 6'd33, 6'd35, 6'd22,
                             6'd21, 6'd51, 6'd40, 6'd26, 6'd18};
    ir = 16'hF825; mem_r = 1'b1; ben = 1'b1; psr15 = 1'b1; intr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (upc !== seq[i] || ctrl !== tag(int'(seq[i]))) begin
        $display("FAIL all_high[%0d] got upc=%0d ctrl=%h want %0d/%h",
                 i, upc, ctrl, seq[i], tag(int'(seq[i]))); n_fail++;
      end
    end
    ir = 16'h0000; mem_r = 1'b0; ben = 1'b0; psr15 = 1'b0; intr = 1'b0;
  endtask

  // Entry: upc=18. Exit: upc=18.
  task automatic test_stall();
    ir = 16'h1234;
    @(negedge clk);
    stall = 1'b1;
    #1;
    n_checks++;
    if (cs_en !== 1'b0 || uop_valid !== 1'b0 || upc !== 6'd32) begin
      $display("FAIL stall_immediate got cs_en=%b valid=%b upc=%0d want 0/0/32",
               cs_en, uop_valid, upc); n_fail++;
    end
    ir = 16'hF025;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (cs_en !== 1'b0 || uop_valid !== 1'b0 || upc !== 6'd32 || ctrl !== tag(32)) begin
        $display("FAIL stall_hold[%0d] got cs_en=%b valid=%b upc=%0d ctrl=%h want 0/0/32/%h",
                 i, cs_en, uop_valid, upc, ctrl, tag(32)); n_fail++;
      end
    end
    stall = 1'b0;
    ir    = 16'h1234;
    #1;
    n_checks++;
    if (uop_valid !== 1'b1 || cs_en !== 1'b1 || cs_addr !== 6'd1) begin
      $display("FAIL stall_release got valid=%b cs_en=%b cs_addr=%0d want 1/1/1",
               uop_valid, cs_en, cs_addr); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd1) begin
      $display("FAIL stall_resume1 got %0d want 1", upc); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (upc !== 6'd18) begin
      $display("FAIL stall_resume2 got %0d want 18", upc); n_fail++;
    end
  endtask

  // Reset while stalled in the memory-wait state, then restart at FETCH.
  task automatic test_reset_mid();
    ir = 16'hF025; mem_r = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (upc !== 6'd33) begin
      $display("FAIL mid_reach33 got %0d want 33", upc); n_fail++;
    end
    stall = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (uop_valid !== 1'b0 || cs_en !== 1'b0 || upc !== 6'd18) begin
      $display("FAIL mid_reset got valid=%b cs_en=%b upc=%0d want 0/0/18",
               uop_valid, cs_en, upc); n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (uop_valid !== 1'b0 || cs_en !== 1'b1 || cs_addr !== 6'd18) begin
      $display("FAIL mid_prime got valid=%b cs_en=%b cs_addr=%0d want 0/1/18",
               uop_valid, cs_en, cs_addr); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (uop_valid !== 1'b1 || upc !== 6'd18 || ctrl !== tag(18)) begin
      $display("FAIL mid_restart got valid=%b upc=%0d ctrl=%h want 1/18/%h",
               uop_valid, upc, ctrl, tag(18)); n_fail++;
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = mk(a, 1'b0, 3'b000, 6'd18);
    rom[18] = mk(18, 1'b0, 3'b000, 6'd32);
    rom[32] = mk(32, 1'b1, 3'b000, 6'd0);
    rom[1]  = mk(1,  1'b0, 3'b000, 6'd18);
    rom[15] = mk(15, 1'b0, 3'b000, 6'd33);
    rom[33] = mk(33, 1'b0, 3'b001, 6'd33);
    rom[35] = mk(35, 1'b0, 3'b010, 6'd18);
    rom[22] = mk(22, 1'b0, 3'b011, 6'd20);
    rom[21] = mk(21, 1'b0, 3'b101, 6'd35);
    rom[51] = mk(51, 1'b0, 3'b000, 6'd40);
    rom[40] = mk(40, 1'b0, 3'b100, 6'd18);
    rom[26] = mk(26, 1'b0, 3'b110, 6'd18);

    rst_n = 1'b0; stall = 1'b0; ir = 16'h0000;
    ben = 1'b0; mem_r = 1'b0; psr15 = 1'b0; intr = 1'b0;

    test_reset();
    test_ird();
    test_mem_wait();
    test_branch();
    test_all_status_high();
    test_stall();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
